muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit that moves every HI/LO-producing multi-cycle operation (MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU) out of the combinational EX datapath. EX starts an operation, holds its stall request while `busy_o` is high, and takes `{hi,lo}` from `result_o` when `ready_o` pulses. One radix-2 step per cycle. Operand width is a parameter, and a pipeline flush can cancel an operation in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Must be ≥ 4. Result is 2·WIDTH.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: request a new operation. Accepted only in IDLE.
- `annul_i`  in  1: flush. Cancels the current operation.
- `op_i`  in  3: operation code.
  - 0 MULT, 1 MULTU, 2 MADD, 3 MADDU
  - 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU
- `opdata1_i`  in  WIDTH: multiplicand or dividend.
- `opdata2_i`  in  WIDTH: multiplier or divisor.
- `hi_i`, `lo_i`  in  WIDTH each: accumulator for MADD*/MSUB*. EX supplies the already-forwarded HI/LO.
- `result_o`  out  2·WIDTH: `{hi,lo}` result.
- `ready_o`  out  1: one-cycle completion pulse.
- `busy_o`  out  1: high in every state except IDLE.
- `div_zero_o`  out  1: divisor was zero. Valid with `ready_o`.

## Operation
- Operands `opdata1_i`, `opdata2_i`, `op_i`, `hi_i` and `lo_i` are all latched at the accepting edge. Inputs are don't-care afterwards.
- State IDLE:
  - On `start_i & ~annul_i`: go to CALC, or to DONE if the op is DIV*/DIVU with a zero divisor.
  - Signed ops latch absolute values of the operands plus the result sign and dividend sign.
  - `start_i` is ignored outside IDLE.
- State CALC, WIDTH cycles, step counter 0..WIDTH-1:
  - Multiply: shift-add on the magnitudes into a 2·WIDTH product.
  - Divide: restoring shift-subtract. Quotient bit is set when the partial remainder ≥ divisor.
- State FIX, 1 cycle:
  - Apply sign correction by two's complement.
  - Signed multiply: product negated when the operand signs differ.
  - Signed divide: quotient is truncated toward zero; remainder takes the dividend's sign.
  - MADD*: `{hi,lo} + product`. MSUB*: `{hi,lo} − product`. Both are mod 2^(2·WIDTH).
  - Go to DONE.
- State DONE, 1 cycle:
  - `ready_o` = 1.
  - Go to IDLE.
- Result layout:
  - Multiply family: `result_o` = 2·WIDTH product or accumulated value.
  - Divide: `result_o` = `{remainder, quotient}`.
  - Divide by zero: `result_o` = 0, `div_zero_o` = 1.
- Overflow case: signed most-negative ÷ −1 gives quotient = most-negative and remainder = 0, with no flag.
- Hold behaviour:
  - `result_o` and `div_zero_o` hold their values from DONE until the next accepted start.
  - At the next accept they clear to 0.
- Annul:
  - In any non-IDLE state, `annul_i` returns the unit to IDLE at the next edge.
  - No `ready_o` pulse is produced. `result_o` is cleared to 0.
  - Annul in DONE suppresses nothing: `ready_o` has already been asserted in that same cycle and stays valid.
  - When `start_i` and `annul_i` are high together in IDLE, annul wins and nothing is accepted.

## Timing
- Reset:
  - State IDLE, counter 0.
  - `result_o` = 0, `ready_o` = 0, `busy_o` = 0, `div_zero_o` = 0.
  - Reset in any state, including mid-CALC, takes effect at the next edge.
- Normal latency: start sampled in cycle 0.
  - CALC occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - `ready_o` is high in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: `ready_o` is high in cycle 1.
- Back-to-back: the earliest next accept is the cycle after DONE. Throughput is one op per WIDTH+3 cycles.
- `busy_o` rises in cycle 1 and falls in the cycle after DONE.
- All outputs are registered.

## Configuration
- `MULDIV_ACCUM_EN` defined:
  - MADD/MADDU/MSUB/MSUBU accumulate as described above.
- `MULDIV_ACCUM_EN` undefined:
  - The accumulator datapath and the `hi_i`/`lo_i` latch are removed.
  - Codes 2 and 4 behave as MULT; codes 3 and 5 behave as MULTU.
  - Latency is unchanged.

## Test plan
- MULT, `0xFFFFFFFE` × `0x00000003`, WIDTH=32 → `result_o` = `0xFFFFFFFF_FFFFFFFA` and `ready_o` pulses in cycle 34 only. The same operands with MULTU → `0x00000002_FFFFFFFA`.
- DIV, `0xFFFFFFF9` (−7) ÷ 2 → `result_o` = `{0xFFFFFFFF, 0xFFFFFFFD}`.
- DIVU, `0x80000000` ÷ 3 → `{0x00000002, 0x2AAAAAAA}`.
- DIV, `0x80000000` ÷ `0xFFFFFFFF` → `{0, 0x80000000}`.
- DIVU, `0x12345678` ÷ 0 → `ready_o` in cycle 1, `div_zero_o` = 1, `result_o` = 0.
- MSUB with hi=0, lo=`0x10`, operands 3 and 4 → `{0, 0x00000004}` with the macro defined; `{0, 0x0000000C}` without it.
- Annul in cycle 10 of a MULT → no `ready_o`, `busy_o` low in cycle 11. A new DIVU 100 ÷ 7 started in cycle 11 → `{2, 14}` in cycle 45. A start asserted together with annul in IDLE is not accepted.
- Assert `rst` mid-CALC (cycle 15) → every output is 0 on the next cycle. A subsequent MULTU 5 × 6 → `{0, 30}`. `start_i` pulses during busy are ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for HI/LO operations (one step per cycle).
// Optional MADD/MSUB accumulation is enabled by defining MULDIV_ACCUM_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               div_q, neg_res_q, neg_dvd_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q, busy_q, div_zero_q;
`ifdef MULDIV_ACCUM_EN
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               madd_q, msub_q;
`else
    logic               unused_accum;
    assign unused_accum = ^{hi_i, lo_i};
`endif

    // Operand decode at the accepting edge: signed ops work on magnitudes.
    logic               op_signed, op_div, s1, s2, dz_accept;
    logic [WIDTH-1:0]   abs1, abs2;
    assign op_signed = ~op_i[0];
    assign op_div    = op_i[2] & op_i[1];
    assign s1        = op_signed & opdata1_i[WIDTH-1];
    assign s2        = op_signed & opdata2_i[WIDTH-1];
    assign abs1      = s1 ? -opdata1_i : opdata1_i;
    assign abs2      = s2 ? -opdata2_i : opdata2_i;
    assign dz_accept = op_div && (opdata2_i == '0);

    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_sub, quot_fix, rem_fix;
    logic               rem_ge;
    logic [2*WIDTH-1:0] acc_step_d, prod_fix, fix_res_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_step_d = acc_q;
        fix_res_d  = '0;

        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & a_q};
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge  = rem_sh >= {1'b0, b_q};
        rem_sub = rem_sh[WIDTH-1:0] - b_q;

        if (div_q)
            acc_step_d = {rem_ge ? rem_sub : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};
        else
            acc_step_d = {mul_sum, acc_q[WIDTH-1:1]};

        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_dvd_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_res_q ? -acc_q : acc_q;

        if (div_q)
            fix_res_d = {rem_fix, quot_fix};
        else
            fix_res_d = prod_fix;
`ifdef MULDIV_ACCUM_EN
        if (madd_q)
            fix_res_d = {hi_q, lo_q} + prod_fix;
        else if (msub_q)
            fix_res_d = {hi_q, lo_q} - prod_fix;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_dvd_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_ACCUM_EN
            hi_q       <= '0;
            lo_q       <= '0;
            madd_q     <= 1'b0;
            msub_q     <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        a_q        <= abs1;
                        b_q        <= abs2;
                        acc_q      <= {{WIDTH{1'b0}}, op_div ? abs1 : abs2};
                        div_q      <= op_div;
                        neg_res_q  <= s1 ^ s2;
                        neg_dvd_q  <= s1;
                        cnt_q      <= '0;
                        result_q   <= '0;
                        busy_q     <= 1'b1;
`ifdef MULDIV_ACCUM_EN
                        hi_q       <= hi_i;
                        lo_q       <= lo_i;
                        madd_q     <= (op_i[2:1] == 2'b01);
                        msub_q     <= (op_i[2:1] == 2'b10);
`endif
                        if (dz_accept) begin
                            state_q    <= DONE;
                            ready_q    <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q    <= CALC;
                            div_zero_q <= 1'b0;
                        end
                    end
                end
                CALC, FIX: begin
                    if (annul_i) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        result_q   <= '0;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (state_q == CALC) begin
                        acc_q <= acc_step_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_q   <= '0;
                            state_q <= FIX;
                        end
                    end else begin
                        result_q <= fix_res_d;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                // The pulse already went out this cycle, so annul here changes nothing.
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign div_zero_o = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit (WIDTH=32): directed vectors, latency,
// annul, reset and hold checks. Define MULDIV_ACCUM_EN to check the accumulate build.
module tb_muldiv_unit;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic [2:0]     op_i;
    logic [W-1:0]   opdata1_i, opdata2_i, hi_i, lo_i;
    logic [2*W-1:0] result_o;
    logic           ready_o, busy_o, div_zero_o;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o)
    );

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MADD = 3'd2, MSUB = 3'd4;
    localparam logic [2:0] DIV = 3'd6, DIVU = 3'd7;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dz;
        int             cyc;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                automatic exp_t e = sb.pop_front();
                check({e.name, "_result"}, result_o, e.res);
                check({e.name, "_div_zero"}, 64'(div_zero_o), 64'(e.dz));
                check({e.name, "_ready_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input bit push, input logic [2*W-1:0] res, input logic dz, input int lat);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
        if (push) sb.push_back('{res, dz, cyc + lat, name});
        @(negedge clk);
        start_i = 1'b0; op_i = ~op; opdata1_i = ~a; opdata2_i = ~b; hi_i = ~hi; lo_i = ~lo;
        check({name, "_busy_c1"}, 64'(busy_o), 64'd1);
        if (lat != 1) check({name, "_cleared_c1"}, result_o, 64'd0);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o && sb.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic [2*W-1:0] res, input logic dz, input int lat);
        issue(name, op, a, b, hi, lo, 1'b1, res, dz, lat);
        wait_idle(name);
        check({name, "_hold"}, result_o, res);
        check({name, "_hold_dz"}, 64'(div_zero_o), 64'(dz));
    endtask

    int c0;

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_dz", 64'(div_zero_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("mult",    MULT,  32'hFFFFFFFE, 32'h3, '0, '0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 34);
        run("multu",   MULTU, 32'hFFFFFFFE, 32'h3, '0, '0, 64'h00000002_FFFFFFFA, 1'b0, 34);
        run("div_neg", DIV,   32'hFFFFFFF9, 32'h2, '0, '0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34);
        run("div_nd",  DIV,   32'h7, 32'hFFFFFFFE, '0, '0, 64'h00000001_FFFFFFFD, 1'b0, 34);
        run("divu",    DIVU,  32'h80000000, 32'h3, '0, '0, 64'h00000002_2AAAAAAA, 1'b0, 34);
        run("div_ovf", DIV,   32'h80000000, 32'hFFFFFFFF, '0, '0, 64'h00000000_80000000, 1'b0, 34);
        run("div_zero", DIVU, 32'h12345678, 32'h0, '0, '0, 64'd0, 1'b1, 1);
`ifdef MULDIV_ACCUM_EN
        run("msub", MSUB, 32'd3, 32'd4, 32'h0, 32'h10, 64'h00000000_00000004, 1'b0, 34);
        run("madd", MADD, 32'd2, 32'd3, 32'h1, 32'hFFFFFFFF, 64'h00000002_00000005, 1'b0, 34);
`else
        run("msub", MSUB, 32'd3, 32'd4, 32'h0, 32'h10, 64'h00000000_0000000C, 1'b0, 34);
        run("madd", MADD, 32'd2, 32'd3, 32'h1, 32'hFFFFFFFF, 64'h00000000_00000006, 1'b0, 34);
`endif

        // Annul in cycle 10 of a MULT, then DIVU 100/7 started in cycle 11.
        c0 = cyc;
        issue("annul_mult", MULT, 32'd7, 32'd9, '0, '0, 1'b0, '0, 1'b0, 34);
        while (cyc < c0 + 10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        check("annul_cycle", 64'(cyc - c0), 64'd11);
        issue("divu_after_annul", DIVU, 32'd100, 32'd7, '0, '0, 1'b1, 64'h00000002_0000000E, 1'b0, 34);
        wait_idle("divu_after_annul");

        // start together with annul in IDLE must not be accepted.
        start_i = 1'b1; annul_i = 1'b1; op_i = DIVU; opdata1_i = 32'd1; opdata2_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        check("start_annul_busy2", 64'(busy_o), 64'd0);

        // Reset in cycle 15 of a MULT.
        c0 = cyc;
        issue("rst_mult", MULT, 32'd11, 32'd13, '0, '0, 1'b0, '0, 1'b0, 34);
        while (cyc < c0 + 15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", result_o, 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_dz", 64'(div_zero_o), 64'd0);

        // MULTU 5x6 with start pulses while busy that must be ignored.
        issue("multu_5x6", MULTU, 32'd5, 32'd6, '0, '0, 1'b1, 64'd30, 1'b0, 34);
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1; op_i = DIVU; opdata1_i = 32'd1; opdata2_i = 32'd0;
            @(negedge clk);
            start_i = 1'b0;
            @(negedge clk);
        end
        wait_idle("multu_5x6");
        check("multu_5x6_hold", result_o, 64'd30);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
